rsa_ctrl: RTL and testbench

Sequencer for the X×Y systolic MAC array (RSA). It accepts one matrix-multiply command, then streams operands from a valid/ready source into the array's west (Xin) and north (Yin) input FIFOs. It then pulses SA_start, waits a fixed compute window, drains all X*Y results through the array's out_rdy/out_data port, and reports completion. It sits between the EKF datapath scheduler (command side) and one RSA instance.

---
 rtl/rsa_pkg.sv | 44 ++++
 rtl/rsa_rd_pipe.sv | 42 ++++
 rtl/rsa_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_rsa_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the systolic-array sequencer: state encoding, default geometry, width helpers.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Contents:
//   rsa_state_e      - sequencer state encoding
//   DEF_*            - default array geometry and timing
//   DEF_*_WORDS      - derived word counts for the default geometry
//   cnt_width()      - counter width for a given maximum count
//   max_int()        - integer max, usable in constant expressions
package rsa_pkg;

    localparam int DEF_X       = 3;
    localparam int DEF_N       = 4;
    localparam int DEF_Y       = 3;
    localparam int DEF_IN_LEN  = 8;
    localparam int DEF_OUT_LEN = 8;
    localparam int DEF_CAL_CYC = 12;
    localparam int DEF_RD_LAT  = 2;

    localparam int DEF_X_WORDS   = DEF_X * DEF_N;
    localparam int DEF_Y_WORDS   = DEF_Y * DEF_N;
    localparam int DEF_OUT_WORDS = DEF_X * DEF_Y;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_X = 3'd1,
        ST_LOAD_Y = 3'd2,
        ST_START  = 3'd3,
        ST_CALC   = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_FLUSH  = 3'd6
    } rsa_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width able to hold every value 0..max_cnt.
    function automatic int cnt_width(input int max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/rsa_rd_pipe.sv
// Read-latency tracker: delays a read strobe by LAT cycles to mark when array output data is valid.
// Latency: LAT cycles from push_i to vld_o.
// Backpressure: none; one push per cycle is always accepted.
//
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   push_i         - read strobe issued to the array this cycle
//   vld_o          - data returned by the array is valid this cycle
//   empty_nxt_o    - no strobe will still be in flight next cycle
module rsa_rd_pipe
    import rsa_pkg::*;
#(
    parameter int LAT = DEF_RD_LAT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    output logic vld_o,
    output logic empty_nxt_o
);

    logic [LAT-1:0] sr_q;
    logic [LAT-1:0] sr_d;

    // Bit 0 is the newest strobe, bit LAT-1 the one whose data arrives now.
    always_comb begin
        sr_d    = sr_q << 1;
        sr_d[0] = push_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign vld_o       = sr_q[LAT-1];
    assign empty_nxt_o = ~|sr_d;

endmodule

// File: rtl/rsa_ctrl.sv
// Sequencer for one XxY systolic MAC array: load operands, start, wait, drain results, report done.
// Latency: operand strobe 1 cycle after accept; SA_start 1 cycle after last north strobe; results RD_LAT after out_rdy.
// Backpressure: src stalls only via src_val; commands only taken in IDLE; result side has none (sink 1 word/cycle).
//
// Ports:
//   clk, sys_rst_n              - clock, asynchronous active-low reset
//   cmd_val / cmd_rdy           - one matrix-multiply command; cmd_rdy only in IDLE
//   src_val / src_rdy, src_data - operand stream: X*N west words, then Y*N north words
//   Xin_val, Yin_val, in_data   - west / north FIFO write strobes and shared data bus
//   SA_start                    - one-cycle array start pulse
//   out_rdy / out_data          - array result read strobe and returned data
//   res_val / res_data          - result stream, row-major
//   busy, done                  - not-idle flag and end-of-drain pulse
module rsa_ctrl
    import rsa_pkg::*;
#(
    parameter int X       = DEF_X,
    parameter int N       = DEF_N,
    parameter int Y       = DEF_Y,
    parameter int IN_LEN  = DEF_IN_LEN,
    parameter int OUT_LEN = DEF_OUT_LEN,
    parameter int CAL_CYC = DEF_CAL_CYC,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               cmd_val,
    output logic               cmd_rdy,
    input  logic               src_val,
    input  logic [IN_LEN-1:0]  src_data,
    output logic               src_rdy,
    output logic               Xin_val,
    output logic               Yin_val,
    output logic [IN_LEN-1:0]  in_data,
    output logic               SA_start,
    output logic               out_rdy,
    input  logic [OUT_LEN-1:0] out_data,
    output logic               res_val,
    output logic [OUT_LEN-1:0] res_data,
    output logic               busy,
    output logic               done
);

    localparam int X_WORDS   = X * N;
    localparam int Y_WORDS   = Y * N;
    localparam int OUT_WORDS = X * Y;

    // One counter is shared by the load, compute and drain phases.
    localparam int CNT_W = cnt_width(max_int(max_int(X_WORDS, Y_WORDS),
                                             max_int(OUT_WORDS, CAL_CYC)));

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(X_WORDS - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(Y_WORDS - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_WORDS - 1);
    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(CAL_CYC - 1);

    rsa_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cmd_rdy_q;
    logic               busy_q;
    logic               src_rdy_q;
    logic               xin_val_q;
    logic               yin_val_q;
    logic [IN_LEN-1:0]  in_data_q;
    logic               sa_start_q;
    logic               out_rdy_q;
    logic               done_q;

    logic               src_acc;
    logic               rd_vld;
    logic               rd_empty_nxt;

    // src_rdy_q is high exactly in LOAD_X and LOAD_Y, so a handshake implies a load state.
    assign src_acc = src_val & src_rdy_q;

    // All control outputs are registered and updated on the transition into the
    // state they belong to, so each output lines up with its state cycle.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmd_rdy_q  <= 1'b1;
            busy_q     <= 1'b0;
            src_rdy_q  <= 1'b0;
            xin_val_q  <= 1'b0;
            yin_val_q  <= 1'b0;
            in_data_q  <= '0;
            sa_start_q <= 1'b0;
            out_rdy_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Strobes and pulses default low; in_data_q holds the last word.
            xin_val_q  <= 1'b0;
            yin_val_q  <= 1'b0;
            sa_start_q <= 1'b0;
            done_q     <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (cmd_val && cmd_rdy_q) begin
                        state_q   <= ST_LOAD_X;
                        cnt_q     <= '0;
                        cmd_rdy_q <= 1'b0;
                        busy_q    <= 1'b1;
                        src_rdy_q <= 1'b1;
                    end
                end

                ST_LOAD_X: begin
                    if (src_acc) begin
                        in_data_q <= src_data;
                        xin_val_q <= 1'b1;
                        if (cnt_q == X_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_LOAD_Y;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                ST_LOAD_Y: begin
                    if (src_acc) begin
                        in_data_q <= src_data;
                        yin_val_q <= 1'b1;
                        if (cnt_q == Y_LAST) begin
                            cnt_q     <= '0;
                            src_rdy_q <= 1'b0;
                            state_q   <= ST_START;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                // START lasts one cycle; the last north strobe is on the bus during it,
                // so SA_start lands on the following cycle, the first of CALC.
                ST_START: begin
                    sa_start_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= ST_CALC;
                end

                ST_CALC: begin
                    if (cnt_q == CAL_LAST) begin
                        cnt_q     <= '0;
                        out_rdy_q <= 1'b1;
                        state_q   <= ST_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (cnt_q == OUT_LAST) begin
                        cnt_q     <= '0;
                        out_rdy_q <= 1'b0;
                        state_q   <= ST_FLUSH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // done is raised for the cycle right after the last result word,
                // then the block returns to IDLE and can take a new command.
                ST_FLUSH: begin
                    if (done_q) begin
                        state_q   <= ST_IDLE;
                        cmd_rdy_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (rd_empty_nxt) begin
                        done_q <= 1'b1;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    cmd_rdy_q <= 1'b1;
                    busy_q    <= 1'b0;
                    src_rdy_q <= 1'b0;
                    out_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    rsa_rd_pipe #(
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i       (clk),
        .rst_ni      (sys_rst_n),
        .push_i      (out_rdy_q),
        .vld_o       (rd_vld),
        .empty_nxt_o (rd_empty_nxt)
    );

    assign cmd_rdy  = cmd_rdy_q;
    assign busy     = busy_q;
    assign src_rdy  = src_rdy_q;
    assign Xin_val  = xin_val_q;
    assign Yin_val  = yin_val_q;
    assign in_data  = in_data_q;
    assign SA_start = sa_start_q;
    assign out_rdy  = out_rdy_q;
    assign done     = done_q;
    assign res_val  = rd_vld;
    // The array bus is only meaningful while a read is landing.
    assign res_data = rd_vld ? out_data : '0;

endmodule

// File: tb/tb_rsa_ctrl.sv
// Bench for rsa_ctrl: randomized operand streams, an array read model, event-timing reference model.
// Latency: n/a.
// Backpressure: src_val patterns held, toggled and random.
module tb_rsa_ctrl;

    localparam int X       = 3;
    localparam int N       = 4;
    localparam int Y       = 3;
    localparam int IN_LEN  = 8;
    localparam int OUT_LEN = 8;
    localparam int CAL_CYC = 12;
    localparam int RD_LAT  = 2;
    localparam int XW      = X * N;
    localparam int YW      = Y * N;
    localparam int OW      = X * Y;
    localparam int TOT     = XW + YW;

    logic               clk       = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic               cmd_val   = 1'b0;
    logic               cmd_rdy;
    logic               src_val   = 1'b0;
    logic [IN_LEN-1:0]  src_data  = '0;
    logic               src_rdy;
    logic               Xin_val;
    logic               Yin_val;
    logic [IN_LEN-1:0]  in_data;
    logic               SA_start;
    logic               out_rdy;
    logic [OUT_LEN-1:0] out_data  = '0;
    logic               res_val;
    logic [OUT_LEN-1:0] res_data;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    rsa_ctrl #(
        .X(X), .N(N), .Y(Y), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN),
        .CAL_CYC(CAL_CYC), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
        .src_val(src_val), .src_data(src_data), .src_rdy(src_rdy),
        .Xin_val(Xin_val), .Yin_val(Yin_val), .in_data(in_data),
        .SA_start(SA_start), .out_rdy(out_rdy), .out_data(out_data),
        .res_val(res_val), .res_data(res_data),
        .busy(busy), .done(done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- event log of the current run ----------------
    int cyc = 0;
    int acc_c[$], xin_c[$], yin_c[$], sa_c[$], ordy_c[$], rv_c[$], done_c[$];
    int xin_d[$], yin_d[$], res_d[$];
    int pend_c[$], pend_d[$];
    int xy_both = 0;
    int rdy_bad = 0;
    int rd_idx  = 0;
    int words[TOT];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (sys_rst_n) begin
            if (cmd_val && cmd_rdy) acc_c.push_back(cyc);
            if (Xin_val) begin xin_c.push_back(cyc); xin_d.push_back(int'(in_data)); end
            if (Yin_val) begin yin_c.push_back(cyc); yin_d.push_back(int'(in_data)); end
            if (Xin_val && Yin_val) xy_both++;
            if (cmd_rdy == busy) rdy_bad++;
            if (SA_start) sa_c.push_back(cyc);
            if (out_rdy) begin
                // Array model: result k of the drain is element (k/Y, k%Y), valued i*10+j (1-based).
                ordy_c.push_back(cyc);
                pend_c.push_back(cyc + RD_LAT);
                pend_d.push_back((rd_idx / Y + 1) * 10 + (rd_idx % Y + 1));
                rd_idx++;
            end
            if (res_val) begin rv_c.push_back(cyc); res_d.push_back(int'(res_data)); end
            if (done) done_c.push_back(cyc);
        end
    end

    // Array read port: data appears RD_LAT cycles after the out_rdy cycle, garbage otherwise.
    always @(posedge clk) begin
        #1;
        while (pend_c.size() > 0 && pend_c[0] < cyc) begin
            void'(pend_c.pop_front());
            void'(pend_d.pop_front());
        end
        if (pend_c.size() > 0 && pend_c[0] == cyc) begin
            out_data = OUT_LEN'(pend_d[0]);
            void'(pend_c.pop_front());
            void'(pend_d.pop_front());
        end else begin
            out_data = OUT_LEN'(165);
        end
    end

    task automatic clear_mon();
        acc_c.delete(); xin_c.delete(); yin_c.delete(); sa_c.delete();
        ordy_c.delete(); rv_c.delete(); done_c.delete();
        xin_d.delete(); yin_d.delete(); res_d.delete();
        pend_c.delete(); pend_d.delete();
        xy_both = 0; rdy_bad = 0; rd_idx = 0;
    endtask

    function automatic int qf(input int q[$]);
        return (q.size() > 0) ? q[0] : -1000;
    endfunction

    function automatic int ql(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1000;
    endfunction

    task automatic fill_words(input bit seq);
        for (int k = 0; k < TOT; k++)
            words[k] = seq ? (k + 1) : int'($urandom_range(1, 255));
    endtask

    // mode 0: src_val held high, 1: toggled 1010..., 2: random
    task automatic feed(input int mode);
        int k = 0;
        int guard = 0;
        bit tg = 1'b1;
        while (k < TOT && guard < 3000) begin
            @(posedge clk); #1;
            case (mode)
                0:       src_val = 1'b1;
                1:       begin src_val = tg; tg = ~tg; end
                default: src_val = 1'($urandom_range(0, 1));
            endcase
            src_data = IN_LEN'(words[k]);
            @(negedge clk);
            if (src_val && src_rdy) k++;
            guard++;
        end
        @(posedge clk); #1;
        src_val = 1'b0;
        if (k < TOT) check("feed_timeout", k, TOT);
    endtask

    task automatic start_cmd();
        int g = 0;
        @(posedge clk); #1;
        cmd_val = 1'b1;
        @(negedge clk);
        while (!cmd_rdy && g < 200) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        cmd_val = 1'b0;
        if (g >= 200) check("cmd_timeout", 0, 1);
    endtask

    task automatic wait_done(output bit ok);
        int g = 0;
        ok = 1'b0;
        while (!ok && g < 800) begin
            @(negedge clk); #2;
            if (done_c.size() > 0) ok = 1'b1;
            g++;
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic evaluate(input bit exact);
        int bad;
        int idx;
        check("xin_cnt", xin_d.size(), XW);
        check("yin_cnt", yin_d.size(), YW);
        bad = 0;
        for (int i = 0; i < xin_d.size(); i++) if (i >= XW || xin_d[i] != words[i]) bad++;
        check("xin_data_err", bad, 0);
        bad = 0;
        for (int i = 0; i < yin_d.size(); i++) if (i >= YW || yin_d[i] != words[XW + i]) bad++;
        check("yin_data_err", bad, 0);
        check("x_before_y", int'(ql(xin_c) < qf(yin_c)), 1);
        check("xy_overlap", xy_both, 0);
        check("cmdrdy_vs_busy", rdy_bad, 0);
        check("acc_cnt", acc_c.size(), 1);
        check("sa_cnt", sa_c.size(), 1);
        check("sa_after_last_yin", qf(sa_c), ql(yin_c) + 1);
        check("ordy_cnt", ordy_c.size(), OW);
        check("ordy_start", qf(ordy_c), qf(sa_c) + CAL_CYC);
        check("ordy_contig", ql(ordy_c) - qf(ordy_c) + 1, OW);
        check("resv_cnt", rv_c.size(), OW);
        check("resv_lat", qf(rv_c), qf(ordy_c) + RD_LAT);
        check("resv_contig", ql(rv_c) - qf(rv_c) + 1, OW);
        bad = 0;
        idx = 0;
        for (int i = 1; i <= X; i++) begin
            for (int j = 1; j <= Y; j++) begin
                if (idx >= res_d.size() || res_d[idx] != i * 10 + j) bad++;
                idx++;
            end
        end
        check("res_data_err", bad, 0);
        check("done_cnt", done_c.size(), 1);
        check("done_time", qf(done_c), ql(ordy_c) + 1 + RD_LAT);
        if (exact) begin
            check("xin_first", qf(xin_c), qf(acc_c) + 2);
            check("xin_contig", ql(xin_c) - qf(xin_c) + 1, XW);
            check("yin_last", ql(yin_c), qf(acc_c) + TOT + 1);
        end
    endtask

    initial begin
        bit ok;
        int dcy;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_cmd_rdy", int'(cmd_rdy), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_in_data", int'(in_data), 0);
        check("rst_strobes", int'({src_rdy, Xin_val, Yin_val, SA_start, out_rdy, res_val, done}), 0);
        check("rst_res_data", int'(res_data), 0);
        sys_rst_n = 1'b1;

        // ---- run 1: src_val held, data 1..24, cmd_val held high throughout ----
        clear_mon();
        fill_words(1'b1);
        @(posedge clk); #1;
        cmd_val = 1'b1;
        feed(0);
        wait_done(ok);
        evaluate(1'b1);
        dcy = qf(done_c);
        // cmd_val still high: the next command must be taken the cycle after done.
        clear_mon();
        fill_words(1'b0);
        @(posedge clk);
        @(negedge clk); #2;
        check("cmd_after_done", qf(acc_c), dcy + 1);
        @(posedge clk); #1;
        cmd_val = 1'b0;

        // ---- run 2: src_val toggled ----
        feed(1);
        wait_done(ok);
        evaluate(1'b0);

        // ---- run 3: reset in CALC cycle 5 ----
        clear_mon();
        fill_words(1'b0);
        start_cmd();
        feed(2);
        begin
            int g = 0;
            while (sa_c.size() == 0 && g < 400) begin @(negedge clk); g++; end
            check("sa_seen", int'(sa_c.size() > 0), 1);
        end
        repeat (5) @(posedge clk);
        #2;
        check("calc_busy", int'(busy), 1);
        sys_rst_n = 1'b0;
        #1;
        check("arst_cmd_rdy", int'(cmd_rdy), 1);
        check("arst_busy", int'(busy), 0);
        check("arst_in_data", int'(in_data), 0);
        check("arst_strobes", int'({src_rdy, Xin_val, Yin_val, SA_start, out_rdy, res_val, done}), 0);
        repeat (3) @(negedge clk);
        check("arst_hold", int'({busy, out_rdy, done}), 0);
        sys_rst_n = 1'b1;
        clear_mon();

        // ---- runs 4..6: fresh commands with random src_val and data ----
        for (int r = 0; r < 3; r++) begin
            clear_mon();
            fill_words(1'b0);
            start_cmd();
            feed(2);
            wait_done(ok);
            evaluate(1'b0);
        end

        repeat (4) @(negedge clk);
        check("end_idle", int'({cmd_rdy, busy}), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
